z16_instr_encoder: RTL
======================

// Module: z16_instr_encoder
// PURPOSE
//  Encodes Z16 instructions from field form (opcode, rd, rs1, rs2, imm) into 16-bit words.
//  Writes each encoded word sequentially into instruction memory through a single write port.
//  Sits between the program-load path (host/test loader) and the instruction memory.
//  It is the inverse of the Z16 decoder: every word it writes decodes back to the same fields.
// PARAMETERS
//  ADDR_W  8  instruction-memory address width; the write window is 2**ADDR_W words
// PORTS
//  i_clk        in   1       clock; all state changes on the rising edge
//  i_rst        in   1       synchronous, active-high reset
//  i_start      in   1       arm the block: load the address counter from i_base_addr, clear count/err
//  i_base_addr  in   ADDR_W  first write address, sampled when i_start=1
//  i_valid      in   1       field tuple valid
//  o_ready      out  1       block can accept a tuple this cycle
//  i_opcode     in   4       opcode
//  i_rd         in   4       destination register
//  i_rs1        in   4       source register 1
//  i_rs2        in   4       source register 2
//  i_imm        in   16      signed immediate (two's complement)
//  o_mem_we     out  1       instruction-memory write strobe
//  o_mem_addr   out  ADDR_W  write address
//  o_mem_wdata  out  16      encoded instruction
//  o_count      out  ADDR_W+1  words written since the last i_start
//  o_full       out  1       write window exhausted
//  o_err        out  1       sticky: a tuple was rejected
//  o_err_code   out  2       code of the first rejection: 01 = imm out of range, 10 = register out of range
// BEHAVIOUR
//  Reset: state=IDLE; o_ready, o_mem_we, o_full, o_err = 0; o_err_code, o_count, o_mem_addr, o_mem_wdata = 0.
//  FSM:
//   IDLE  -> RUN on i_start.
//   RUN   o_ready=1. A tuple is accepted on the edge where i_valid & o_ready.
//         Legal tuple: encode and register the word -> WRITE.
//         Illegal tuple: consumed, nothing written; set o_err; latch o_err_code only if o_err was 0; stay in RUN.
//   WRITE exactly one cycle; o_ready=0, o_mem_we=1, o_mem_addr = current address, o_mem_wdata = the word.
//         On exit: address+1 and o_count+1.
//         If the address just written was 2**ADDR_W-1 -> FULL; otherwise -> RUN.
//   FULL  o_ready=0, o_full=1; leaves only on i_start (-> RUN) or i_rst.
//  Latency and throughput: word on the memory port 1 cycle after acceptance; at most 1 word per 2 cycles.
//  o_mem_we is 0 outside WRITE. o_mem_addr and o_mem_wdata hold their last values.
//  Encoding (bit [3:0] = opcode in all cases):
//   op 0-8  : [7:4]=rd, [11:8]=rs1, [15:12]=rs2; imm ignored
//   op 9    : [7:4]=rd, [15:8]=imm[7:0]; imm must be in -128..127; rs1 and rs2 ignored
//   op A,C,D: [7:4]=rd, [11:8]=rs1, [15:12]=imm[3:0]; imm must be in -8..7
//   op B    : [7:4]=imm[3:0], [11:8]=rs1, [15:12]=rs2; imm must be in -8..7
//   op E,F  : [5:4]=rs1[1:0], [7:6]=rs2[1:0], [15:8]=imm[7:0]; imm must be in -128..127
//             rs1 and rs2 must be < 4, else reject with code 10. Code 10 takes priority over code 01.
//  Range check: the imm is in range iff every bit above the field's MSB equals the field's sign bit.
//  Simultaneous events:
//   i_start in RUN wins over a valid tuple in the same cycle: the tuple is not accepted.
//   i_start during WRITE: the write completes; the next state is RUN with the counter reloaded
//     (the i_start load overrides the increment).
//   i_rst mid-operation drops any pending write; no o_mem_we pulse follows reset.
// STRUCTURE
//  Shared package z16_pkg: opcode constants (OP_ADDI=9, OP_LD=A, OP_ST=B, OP_BR0=E, OP_BR1=F).
//   Also holds the FSM state enum and the error-code constants.
//   The decoder imports the same opcode constants.
//  Sub-module z16_field_packer: combinational; fields in -> {word, legal, err_code} out.
//  Top level: FSM, address counter, count, sticky error, output registers.
// TESTING
//  1 start base=0x10; op0 rd=1 rs1=2 rs2=3 -> one cycle later we=1, addr=0x10, wdata=0x3210; count=1
//  2 op9 rd=4 imm=-1 -> 0xFF49; opB rs1=2 rs2=5 imm=-3 -> 0x52DB; opE rs1=1 rs2=2 imm=4 -> 0x049E
//  3 opA imm=8 -> no write, err=1, code=01; then opF rs1=5 -> still code=01, no write
//  4 ADDR_W=2, base=0, four legal tuples -> writes at 0..3, then full=1, ready=0; start -> ready=1
//  5 i_valid held high back-to-back -> ready toggles 1/0, one we pulse per 2 cycles
//  6 i_rst during WRITE -> we=0 next cycle, outputs at reset values; start with i_valid in same cycle -> not accepted
//  Bench feeds every written word to the Z16 decoder and checks the recovered fields against the stimulus.

Source files
------------

// File: rtl/z16_pkg.sv
// Shared Z16 definitions: opcodes, encoder FSM states, rejection codes and
// immediate range helpers. The decoder imports the same opcode constants.
package z16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_RI_C = 4'hC;
  localparam logic [3:0] OP_RI_D = 4'hD;
  localparam logic [3:0] OP_BR0  = 4'hE;
  localparam logic [3:0] OP_BR1  = 4'hF;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_IMM  = 2'b01;
  localparam logic [1:0] ERR_REG  = 2'b10;

  // An immediate fits a signed field when every bit above the field MSB
  // repeats the field's sign bit.
  function automatic logic fits_imm8(input logic [15:0] imm);
    return (&imm[15:7]) | ~(|imm[15:7]);
  endfunction

  function automatic logic fits_imm4(input logic [15:0] imm);
    return (&imm[15:3]) | ~(|imm[15:3]);
  endfunction

endpackage

// File: rtl/z16_field_packer.sv
// Combinational Z16 field packer: builds the 16-bit word and reports whether
// the field tuple is encodable, with the rejection code when it is not.
module z16_field_packer
  import z16_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [15:0] imm,
  output logic [15:0] word,
  output logic        legal,
  output logic [1:0]  err_code
);

  always_comb begin
    word     = {rs2, rs1, rd, opcode};
    legal    = 1'b1;
    err_code = ERR_NONE;
    case (opcode)
      OP_ADDI: begin
        word = {imm[7:0], rd, opcode};
        if (!fits_imm8(imm)) begin
          legal    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      OP_LD, OP_RI_C, OP_RI_D: begin
        word = {imm[3:0], rs1, rd, opcode};
        if (!fits_imm4(imm)) begin
          legal    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      OP_ST: begin
        word = {rs2, rs1, imm[3:0], opcode};
        if (!fits_imm4(imm)) begin
          legal    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      // Branches only have 2-bit register fields; a bad register outranks a bad immediate.
      OP_BR0, OP_BR1: begin
        word = {imm[7:0], rs2[1:0], rs1[1:0], opcode};
        if ((|rs1[3:2]) || (|rs2[3:2])) begin
          legal    = 1'b0;
          err_code = ERR_REG;
        end else if (!fits_imm8(imm)) begin
          legal    = 1'b0;
          err_code = ERR_IMM;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z16_instr_encoder.sv
// Z16 instruction encoder: accepts field tuples, packs them and streams the
// words into instruction memory at consecutive addresses from a base.
module z16_instr_encoder
  import z16_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [3:0]        i_opcode,
  input  logic [3:0]        i_rd,
  input  logic [3:0]        i_rs1,
  input  logic [3:0]        i_rs2,
  input  logic [15:0]       i_imm,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err,
  output logic [1:0]        o_err_code
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  logic [15:0]       packed_word;
  logic              packed_legal;
  logic [1:0]        packed_code;

  z16_field_packer u_packer (
    .opcode   (i_opcode),
    .rd       (i_rd),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .imm      (i_imm),
    .word     (packed_word),
    .legal    (packed_legal),
    .err_code (packed_code)
  );

  assign o_ready  = (state == ST_RUN);
  assign o_mem_we = (state == ST_WRITE);
  assign o_full   = (state == ST_FULL);

  // i_start always wins: it re-arms from any state except IDLE-less reset.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: if (i_start) next_state = ST_RUN;
      ST_RUN: begin
        if (i_start) begin
          next_state = ST_RUN;
        end else if (i_valid) begin
          accept = 1'b1;
          if (packed_legal) next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_start)                          next_state = ST_RUN;
        else if (o_mem_addr == {ADDR_W{1'b1}}) next_state = ST_FULL;
        else                                  next_state = ST_RUN;
      end
      ST_FULL: if (i_start) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      o_count     <= '0;
      o_err       <= 1'b0;
      o_err_code  <= ERR_NONE;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      state <= next_state;
      if (i_start) begin
        addr_q     <= i_base_addr;
        o_count    <= '0;
        o_err      <= 1'b0;
        o_err_code <= ERR_NONE;
      end else if (state == ST_WRITE) begin
        addr_q  <= addr_q + 1'b1;
        o_count <= o_count + 1'b1;
      end
      // Only the first rejection since arming is remembered in the code.
      if (accept) begin
        if (packed_legal) begin
          o_mem_addr  <= addr_q;
          o_mem_wdata <= packed_word;
        end else begin
          o_err <= 1'b1;
          if (!o_err) o_err_code <= packed_code;
        end
      end
    end
  end

endmodule
